// File: rtl/rotate_pkg.sv
// ---------------------------------------------------------------------------
// rotate_pkg
//
// Purpose : Shared definitions for the inverse rho (lane-rotate) stage.
//           Holds the state geometry, the 25-entry rho offset table
//           (indexed by lane i = 5*y + x) and the FSM state enum.
//
// Contents:
//   SLICE_W     - bits per slice (lane count), fixed at 25 by the table
//   DEPTH       - slices per state (lane length), power of two
//   CNT_W       - width of the slice counter / rotate amount
//   LANE_W      - width of the lane counter
//   RHO_TABLE   - rho offsets, lane-ordered
//   rhoOffset() - offset of a lane reduced mod DEPTH
//   state_e     - IDLE / LOAD / ROT / DRAIN
//
// Optional feature macro used by the files importing this package:
//   ROTATE_INV_DIR_SEL_EN
// ---------------------------------------------------------------------------
package rotate_pkg;

    localparam int SLICE_W = 25;
    localparam int DEPTH   = 64;
    localparam int CNT_W   = $clog2(DEPTH);
    localparam int LANE_W  = $clog2(SLICE_W);

    // Lane-ordered offsets: entry i holds R[x][y] with i = 5*y + x.
    localparam int RHO_TABLE [SLICE_W] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROT   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Offsets are taken mod DEPTH so that the rotate amount fits CNT_W bits.
    function automatic logic [CNT_W-1:0] rhoOffset(input logic [LANE_W-1:0] lane);
        if (int'(lane) < SLICE_W) begin
            return CNT_W'(RHO_TABLE[lane] % DEPTH);
        end
        return '0;
    endfunction

endpackage

// File: rtl/rotate_inv_stream_lane_rotator.sv
// ---------------------------------------------------------------------------
// lane_rotator
//
// Purpose : Combinational DEPTH-bit barrel rotator for one lane.
//           Default direction is a right rotate: lane_o[z] = lane_i[(z + amount_i) mod DEPTH].
//           With ROTATE_INV_DIR_SEL_EN defined, dir_i = 1 selects the forward (left)
//           rotate: lane_o[z] = lane_i[(z - amount_i) mod DEPTH].
//
// Ports   :
//   lane_i   [DEPTH-1:0] - lane column, bit z = slice z
//   amount_i [CNT_W-1:0] - rotate amount
//   dir_i                - direction select (only with ROTATE_INV_DIR_SEL_EN)
//   lane_o   [DEPTH-1:0] - rotated lane column
// ---------------------------------------------------------------------------
module lane_rotator
    import rotate_pkg::*;
(
    input  logic [DEPTH-1:0] lane_i,
    input  logic [CNT_W-1:0] amount_i,
`ifdef ROTATE_INV_DIR_SEL_EN
    input  logic             dir_i,
`endif
    output logic [DEPTH-1:0] lane_o
);

    logic [CNT_W-1:0] rightAmt;
    logic [DEPTH-1:0] rotated;

    // A left rotate by R is the same as a right rotate by (DEPTH - R) mod DEPTH,
    // so only one log-stage right rotator is built and the amount is negated
    // for the forward direction. Each stage rotates by a power of two.
    always_comb begin
        rightAmt = amount_i;
`ifdef ROTATE_INV_DIR_SEL_EN
        if (dir_i) begin
            rightAmt = CNT_W'(0) - amount_i;
        end
`endif
        rotated = lane_i;
        for (int s = 0; s < CNT_W; s++) begin
            if (rightAmt[s]) begin
                rotated = (rotated >> (1 << s)) | (rotated << (DEPTH - (1 << s)));
            end
        end
        lane_o = rotated;
    end

endmodule

// File: rtl/rotate_inv_stream.sv
// ---------------------------------------------------------------------------
// rotate_inv_stream
//
// Purpose : Inverse rho stage of the matrix decoder path. Buffers one
//           64-slice state received over a valid/ready stream, rotates each
//           of the 25 lanes right by its rho offset (one lane per cycle),
//           then streams the 64 slices back out in order z = 0..63.
//
// Ports   :
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   dir        - rotate direction, 1 = forward (only with ROTATE_INV_DIR_SEL_EN)
//   in_valid   - in_slice is valid
//   in_ready   - block accepts a slice this cycle
//   in_slice   - input slice, k-th accepted slice is z = k
//   out_valid  - out_slice is valid
//   out_ready  - downstream accepts out_slice
//   out_slice  - output slice, emitted z = 0..63
//   busy       - high in any state other than IDLE
//   done       - one-cycle pulse after the last output handshake
//
// Optional feature macro: ROTATE_INV_DIR_SEL_EN (adds the dir port).
// ---------------------------------------------------------------------------
module rotate_inv_stream
    import rotate_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
`ifdef ROTATE_INV_DIR_SEL_EN
    input  logic               dir,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SLICE_W-1:0] in_slice,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_slice,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0]  LAST_SLICE = CNT_W'(DEPTH - 1);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(SLICE_W - 1);

    state_e               state_q,    state_d;
    logic [CNT_W-1:0]     sliceCnt_q, sliceCnt_d;
    logic [LANE_W-1:0]    laneCnt_q,  laneCnt_d;
    logic                 inReady_q,  inReady_d;
    logic                 outValid_q, outValid_d;
    logic [SLICE_W-1:0]   outSlice_q, outSlice_d;
    logic                 done_q,     done_d;

    logic [DEPTH-1:0]     laneBuf_q [SLICE_W];
    logic                 inFire;
    logic [CNT_W-1:0]     readIdx;
    logic [SLICE_W-1:0]   readSlice;
    logic [DEPTH-1:0]     rotatedLane;

`ifdef ROTATE_INV_DIR_SEL_EN
    logic                 dir_q, dir_d;
`endif

    assign inFire    = in_valid & inReady_q;
    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_slice = outSlice_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

    lane_rotator u_lane_rotator (
        .lane_i   (laneBuf_q[laneCnt_q]),
        .amount_i (rhoOffset(laneCnt_q)),
`ifdef ROTATE_INV_DIR_SEL_EN
        .dir_i    (dir_q),
`endif
        .lane_o   (rotatedLane)
    );

    // The buffer is stored lane-major so that ROT can read and rewrite a whole
    // lane column in one cycle. While draining, the slice loaded into the output
    // register is the current one on the first DRAIN cycle and the following
    // one on each handshake, which keeps full throughput with no bubble.
    always_comb begin
        readIdx = sliceCnt_q;
        if (state_q == DRAIN && outValid_q) begin
            readIdx = sliceCnt_q + CNT_W'(1);
        end
        readSlice = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            readSlice[i] = laneBuf_q[i][readIdx];
        end
    end

    // Next-state logic. ROT always takes exactly one cycle per lane; the first
    // DRAIN cycle only fills the output register, because the last lane is
    // written back on the same edge that enters DRAIN.
    always_comb begin
        state_d    = state_q;
        sliceCnt_d = sliceCnt_q;
        laneCnt_d  = laneCnt_q;
        outValid_d = outValid_q;
        outSlice_d = outSlice_q;
        done_d     = 1'b0;
`ifdef ROTATE_INV_DIR_SEL_EN
        dir_d      = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (inFire) begin
                    sliceCnt_d = CNT_W'(1);
                    state_d    = LOAD;
`ifdef ROTATE_INV_DIR_SEL_EN
                    dir_d      = dir;
`endif
                end
            end
            LOAD: begin
                if (inFire) begin
                    sliceCnt_d = sliceCnt_q + CNT_W'(1);
                    if (sliceCnt_q == LAST_SLICE) begin
                        state_d = ROT;
                    end
                end
            end
            ROT: begin
                if (laneCnt_q >= LAST_LANE) begin
                    laneCnt_d = '0;
                    state_d   = DRAIN;
                end else begin
                    laneCnt_d = laneCnt_q + LANE_W'(1);
                end
            end
            DRAIN: begin
                if (!outValid_q) begin
                    outValid_d = 1'b1;
                    outSlice_d = readSlice;
                end else if (out_ready) begin
                    sliceCnt_d = sliceCnt_q + CNT_W'(1);
                    if (sliceCnt_q == LAST_SLICE) begin
                        state_d    = IDLE;
                        outValid_d = 1'b0;
                        outSlice_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        outSlice_d = readSlice;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        inReady_d = (state_d == IDLE) || (state_d == LOAD);
    end

    // Control registers. in_ready is registered so that it reads low while
    // reset is held and rises on the first clock after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sliceCnt_q <= '0;
            laneCnt_q  <= '0;
            inReady_q  <= 1'b0;
            outValid_q <= 1'b0;
            outSlice_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sliceCnt_q <= sliceCnt_d;
            laneCnt_q  <= laneCnt_d;
            inReady_q  <= inReady_d;
            outValid_q <= outValid_d;
            outSlice_q <= outSlice_d;
            done_q     <= done_d;
        end
    end

`ifdef ROTATE_INV_DIR_SEL_EN
    // Direction is captured with the first slice and held for the whole state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    // State buffer has no reset; its contents are meaningless until loaded.
    // Incoming slices scatter one bit into every lane; in ROT the current lane
    // is replaced by its rotated copy.
    always_ff @(posedge clk) begin
        if (inFire) begin
            for (int i = 0; i < SLICE_W; i++) begin
                laneBuf_q[i][sliceCnt_q] <= in_slice[i];
            end
        end else if (state_q == ROT) begin
            laneBuf_q[laneCnt_q] <= rotatedLane;
        end
    end

endmodule

// File: tb/tb_rotate_inv_stream.sv
// ---------------------------------------------------------------------------
// tb_rotate_inv_stream
//
// Purpose : Self-checking bench for rotate_inv_stream using directed vectors.
//           Expected outputs are hand-computed constants or produced by an
//           encoder-side left rotate written from the x/y offset table.
//
// Optional feature macro: ROTATE_INV_DIR_SEL_EN (adds the dir round trip).
// ---------------------------------------------------------------------------
module tb_rotate_inv_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_slice;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_slice;
    logic        busy;
    logic        done;
`ifdef ROTATE_INV_DIR_SEL_EN
    logic        dir;
`endif

    int checks;
    int errors;

    logic [24:0] stim    [64];
    logic [24:0] expSt   [64];
    logic [24:0] got     [64];
    logic [24:0] orig    [64];

    // Offsets laid out as R[x][y], rows x, columns y.
    int rhoXY [5][5] = '{
        '{ 0, 36,  3, 41, 18},
        '{ 1, 44, 10, 45,  2},
        '{62,  6, 43, 15, 61},
        '{28, 55, 25, 21, 56},
        '{27, 20, 39,  8, 14}
    };

    rotate_inv_stream dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ROTATE_INV_DIR_SEL_EN
        .dir       (dir),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_slice  (in_slice),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_slice (out_slice),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backstop in case a bounded loop is ever mis-sized.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearStim();
        for (int z = 0; z < 64; z++) begin
            stim[z]  = '0;
            expSt[z] = '0;
        end
    endtask

    // Encoder-side rho: lane (x,y) rotated left by R[x][y].
    task automatic encodeOrig();
        for (int z = 0; z < 64; z++) begin
            for (int x = 0; x < 5; x++) begin
                for (int y = 0; y < 5; y++) begin
                    stim[z][5*y+x] = orig[(z - rhoXY[x][y] + 64) % 64][5*y+x];
                end
            end
        end
    endtask

    // Streams stim[] in, then measures cycles until the first out_valid.
    task automatic applyStimulus(input string tag);
        int idx = 0;
        int guard = 0;
        int latency = 0;
        while (idx < 64 && guard < 500) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b1;
            in_slice = stim[idx];
            if (in_ready) begin
                idx++;
            end
        end
        if (idx < 64) begin
            checkOutput({tag, "_load_timeout"}, 64'(idx), 64'd64);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_slice = '0;
        checkOutput({tag, "_in_ready_rot"}, 64'(in_ready), 64'd0);
        checkOutput({tag, "_busy_rot"}, 64'(busy), 64'd1);
        while (!out_valid && latency < 100) begin
            latency++;
            @(negedge clk);
        end
        checkOutput({tag, "_latency"}, 64'(latency), 64'd26);
    endtask

    // Collects stopAfter output slices into got[]; optional 0/1 out_ready toggling.
    // A full drain also checks the done pulse and that no extra slice appears.
    task automatic drainOutput(input string tag, input bit toggle, input int stopAfter);
        int hs = 0;
        int guard = 0;
        int doneCnt = 0;
        bit stalled = 1'b0;
        logic [24:0] held = '0;
        while (hs < stopAfter && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (done) begin
                doneCnt++;
            end
            if (stalled) begin
                checkOutput({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
                checkOutput({tag, "_stall_hold"}, 64'(out_slice), 64'(held));
            end
            out_ready = toggle ? ((guard % 2) == 0) : 1'b1;
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                got[hs] = out_slice;
                hs++;
            end else if (out_valid) begin
                stalled = 1'b1;
                held = out_slice;
            end
        end
        if (hs < stopAfter) begin
            checkOutput({tag, "_drain_timeout"}, 64'(hs), 64'(stopAfter));
        end
        if (stopAfter == 64) begin
            for (int t = 0; t < 4; t++) begin
                @(negedge clk);
                out_ready = 1'b1;
                if (done) begin
                    doneCnt++;
                end
                if (out_valid) begin
                    hs++;
                end
            end
            out_ready = 1'b0;
            checkOutput({tag, "_handshakes"}, 64'(hs), 64'd64);
            checkOutput({tag, "_done_pulses"}, 64'(doneCnt), 64'd1);
            checkOutput({tag, "_busy_idle"}, 64'(busy), 64'd0);
            checkOutput({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        end
    endtask

    task automatic compareState(input string tag);
        for (int z = 0; z < 64; z++) begin
            checkOutput($sformatf("%s_z%0d", tag, z), 64'(got[z]), 64'(expSt[z]));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_slice  = '0;
        out_ready = 1'b0;
`ifdef ROTATE_INV_DIR_SEL_EN
        dir       = 1'b0;
`endif

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_slice", 64'(out_slice), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Lane 1 (offset 1), single bit at z=0 lands at z=63.
        clearStim();
        stim[0]   = 25'h0000002;
        expSt[63] = 25'h0000002;
        applyStimulus("lane1");
        drainOutput("lane1", 1'b0, 64);
        compareState("lane1");

        // Lane 6 (offset 44) bit at z=44 lands at z=0; lane 0 bit at z=5 stays put.
        clearStim();
        stim[44] = 25'h0000040;
        stim[5]  = 25'h0000001;
        expSt[0] = 25'h0000040;
        expSt[5] = 25'h0000001;
        applyStimulus("lane6");
        drainOutput("lane6", 1'b0, 64);
        compareState("lane6");

        // Random state through the encoder rotate must come back unchanged,
        // drained with out_ready toggling to exercise stalls.
        for (int z = 0; z < 64; z++) begin
            orig[z]  = 25'($urandom);
            expSt[z] = orig[z];
        end
        encodeOrig();
        applyStimulus("rand");
        drainOutput("rand", 1'b1, 64);
        compareState("rand");

        // Reset in the middle of DRAIN, then a fresh load must work.
        for (int z = 0; z < 64; z++) begin
            stim[z] = 25'($urandom);
        end
        applyStimulus("abort");
        drainOutput("abort", 1'b0, 30);
        @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_out_slice", 64'(out_slice), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_no_done", 64'(done), 64'd0);
        clearStim();
        stim[44] = 25'h0000040;
        stim[5]  = 25'h0000001;
        expSt[0] = 25'h0000040;
        expSt[5] = 25'h0000001;
        applyStimulus("reload");
        drainOutput("reload", 1'b0, 64);
        compareState("reload");

`ifdef ROTATE_INV_DIR_SEL_EN
        // Forward pass then inverse pass must be the identity; the forward
        // pass alone must match the encoder-side rotate.
        for (int z = 0; z < 64; z++) begin
            orig[z] = 25'($urandom);
        end
        encodeOrig();
        for (int z = 0; z < 64; z++) begin
            expSt[z] = stim[z];
            stim[z]  = orig[z];
        end
        dir = 1'b1;
        applyStimulus("fwd");
        dir = 1'b0;
        drainOutput("fwd", 1'b0, 64);
        compareState("fwd");
        for (int z = 0; z < 64; z++) begin
            stim[z]  = got[z];
            expSt[z] = orig[z];
        end
        dir = 1'b0;
        applyStimulus("inv");
        dir = 1'b1;
        drainOutput("inv", 1'b0, 64);
        compareState("inv");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
